ring_phase_monitor: RTL and testbench
=====================================

# ring_phase_monitor

Downstream checker and decoder for the one-hot ring counter. It samples the ring's `WIDTH`-bit phase vector every clock and verifies that the vector is one-hot and advances by exactly one position per qualified cycle. It encodes the hot bit to a binary phase index, counts completed revolutions, and reports sticky error flags plus an error count for the rest of the design.

## Interface

Parameters:
- `WIDTH`, default 4: ring width; number of phases.
- `REV_W`, default 8: revolution counter width.
- `ERR_W`, default 4: error counter width.

Ports:
- `CLK`  in  1  rising-edge clock; same clock as the ring counter.
- `CLR`  in  1  reset; asynchronous, active-low.
- `ring_in`  in  WIDTH  phase vector from the ring counter; legal sequence is bit0→bit1→…→bit(WIDTH-1)→bit0.
- `enable`  in  1  sample qualifier; when low, the edge is ignored.
- `clear_err`  in  1  synchronous clear of the sticky flags and `err_count`.
- `phase_idx`  out  clog2(WIDTH)  binary index of the last legal one-hot sample.
- `phase_valid`  out  1  the last qualified sample was one-hot.
- `locked`  out  1  the monitor is in LOCKED.
- `rev_count`  out  REV_W  completed revolutions while locked; wraps modulo 2^REV_W.
- `rev_tick`  out  1  one-cycle pulse coinciding with a `rev_count` increment.
- `err_onehot`  out  1  sticky: a non-one-hot sample was seen while locked.
- `err_seq`  out  1  sticky: a one-hot sample that is not the expected rotation was seen while locked.
- `err_count`  out  ERR_W  count of errors detected in LOCKED; saturates at all-ones.

## Operation

- Define `onehot(x)` as exactly one bit set in `x`.
- Define `rotl(p) = {p[WIDTH-2:0], p[WIDTH-1]}`.
- `prev` is an internal WIDTH-bit register holding the last one-hot sample.
- Every action below happens only on a CLK edge with `enable`=1. With `enable`=0, all state, `prev` and outputs hold, except `rev_tick`, which drops to 0.
- State machine:
  - SEARCH:
    - `onehot(ring_in)`: `prev`←`ring_in`, go to ACQUIRE.
    - Otherwise: stay in SEARCH.
  - ACQUIRE:
    - `ring_in == rotl(prev)`: go to LOCKED.
    - Else if `onehot(ring_in)`: stay in ACQUIRE and re-seed `prev`.
    - Else: go to SEARCH.
    - No errors are counted in this state.
  - LOCKED:
    - `ring_in == rotl(prev)`: stay in LOCKED.
    - Non-one-hot sample: set `err_onehot`, count the error, go to SEARCH.
    - One-hot sample but not `rotl(prev)`: set `err_seq`, count the error, go to ACQUIRE with `prev`←`ring_in`.
- `prev` updates on every one-hot sample, in any state.
- `phase_valid` is set to `onehot(ring_in)`.
- `phase_idx` is set to the encoded index on a one-hot sample and holds otherwise.
- Revolution counting: when in LOCKED, `prev[WIDTH-1]`=1, and `ring_in == rotl(prev)` (i.e. `ring_in[0]`=1), increment `rev_count` and pulse `rev_tick`.
  - The ACQUIRE→LOCKED transition edge also counts if it is a wrap.
- `err_count` increments by 1 per error and saturates at 2^ERR_W−1.
- `clear_err`=1 clears both flags and `err_count`, whether or not `enable` is high.
  - If an error is detected on the same edge, the new error wins: its flag=1 and `err_count`=1.
- `rev_count` is never cleared except by `CLR`.

## Timing

- Reset (`CLR`=0) is asynchronous. Immediately on assertion:
  - state=SEARCH, `prev`=0.
  - `phase_idx`=0, `phase_valid`=0, `locked`=0.
  - `rev_count`=0, `rev_tick`=0.
  - `err_onehot`=0, `err_seq`=0, `err_count`=0.
- Reset asserted mid-operation discards any in-progress revolution or error, with no pulse emitted.
- All outputs are registered. A sample taken at edge k is reflected after edge k; there are no combinational input-to-output paths.
- Lock latency: two consecutive legal samples. `locked`=1 after the second edge.
- Error detection: flags, count and `locked`=0 all appear after the offending edge.
- `rev_tick` is high for exactly one cycle per revolution.
- Reset values matter to the ring: it resets to phase 0001 in the same cycle, so the first qualified sample after reset release is normally 0001.

## Test plan

1. Reset, then `ring_in` 0001, 0010, 0100, 1000, 0001 with `enable`=1:
   - `locked`=1 after the 0010 edge.
   - `phase_idx` sequence is 0, 1, 2, 3, 0.
   - `rev_tick` pulses on the final edge; `rev_count`=1; no errors.
2. Locked at 0100, drive 0110:
   - `err_onehot`=1, `err_count`=1, `locked`=0, `phase_valid`=0, `phase_idx` holds 2.
   - Then 0001, 0010: relock after two edges.
3. Locked at 0010, drive 1000:
   - `err_seq`=1, `err_count`=1, state ACQUIRE.
   - Next 0001: `locked`=1, `rev_tick`=1.
4. Locked, then `enable`=0 for 3 cycles with `ring_in` garbage:
   - All outputs hold; no error.
   - Resume with `rotl(prev)`: still locked.
5. `clear_err`=1 on the same edge as a sequence error, with `err_count` previously 5:
   - `err_seq`=1, `err_count`=1.
   - Separately, 20 errors with ERR_W=4: `err_count`=15.
6. REV_W=2, 5 clean revolutions:
   - `rev_count` goes 1, 2, 3, 0, 1.
   - Assert `CLR` mid-revolution: all outputs 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks that a one-hot ring advances one phase per
// qualified cycle; decodes phase, counts revolutions, flags errors.
//
// Ports:
//   CLK, CLR (async active-low reset)
//   ring_in     : WIDTH-bit phase vector from the ring counter
//   enable      : sample qualifier
//   clear_err   : synchronous clear of error flags and err_count
//   phase_idx   : binary index of last legal one-hot sample
//   phase_valid : last qualified sample was one-hot
//   locked      : monitor is tracking the ring
//   rev_count   : completed revolutions (wrapping)
//   rev_tick    : one-cycle pulse per revolution
//   err_onehot  : sticky, non-one-hot sample while locked
//   err_seq     : sticky, out-of-order one-hot sample while locked
//   err_count   : saturating error count
module ring_phase_monitor #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8,
  parameter int ERR_W = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic [IW-1:0]    phase_idx,
  output logic             phase_valid,
  output logic             locked,
  output logic [REV_W-1:0] rev_count,
  output logic             rev_tick,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] nxt;
  logic             in_oh;
  logic             match;
  logic [IW-1:0]    enc;
  logic             e_oh;
  logic             e_sq;
  logic             wrap;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W-1:0] err_nxt;

  assign nxt   = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign match = (ring_in == nxt);
  assign in_oh = (ring_in != '0) &&
                 ((ring_in & (ring_in - WIDTH'(1))) == '0);

  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring_in[i]) enc = IW'(i);
  end

  // A clear on the same edge as a new error restarts the count at 1.
  assign err_base = clear_err ? '0 : err_count;
  assign err_nxt  = (&err_base) ? err_base : err_base + ERR_W'(1);

  always_comb begin
    state_d = state_q;
    e_oh    = 1'b0;
    e_sq    = 1'b0;
    wrap    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (in_oh) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (match) begin
          state_d = LOCKED;
          wrap    = prev_q[WIDTH-1];
        end else if (!in_oh) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (match) begin
          wrap = prev_q[WIDTH-1];
        end else if (!in_oh) begin
          e_oh    = 1'b1;
          state_d = SEARCH;
        end else begin
          e_sq    = 1'b1;
          state_d = ACQUIRE;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= SEARCH;
    else if (enable) state_q <= state_d;
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      prev_q      <= '0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      rev_count   <= '0;
      rev_tick    <= 1'b0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      err_count   <= '0;
    end else begin
      rev_tick <= 1'b0;
      if (clear_err) begin
        err_onehot <= 1'b0;
        err_seq    <= 1'b0;
        err_count  <= '0;
      end
      if (enable) begin
        phase_valid <= in_oh;
        if (in_oh) begin
          prev_q    <= ring_in;
          phase_idx <= enc;
        end
        if (wrap) begin
          rev_count <= rev_count + REV_W'(1);
          rev_tick  <= 1'b1;
        end
        if (e_oh) err_onehot <= 1'b1;
        if (e_sq) err_seq <= 1'b1;
        if (e_oh || e_sq) err_count <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: scoreboard bench for ring_phase_monitor.
// Two instances share stimulus: default widths and REV_W=2.
module tb_ring_phase_monitor;

  typedef struct {
    int idx;
    bit valid;
    bit locked;
    int rev;
    bit tick;
    bit eoh;
    bit esq;
    int ecnt;
  } exp_t;

  logic       CLK;
  logic       CLR;
  logic [3:0] ring_in;
  logic       enable;
  logic       clear_err;

  logic [1:0] idx0;
  logic       valid0, locked0, tick0, eoh0, esq0;
  logic [7:0] rev0;
  logic [3:0] ecnt0;
  logic [1:0] idx1;
  logic       valid1, locked1, tick1, eoh1, esq1;
  logic [1:0] rev1;
  logic [3:0] ecnt1;

  ring_phase_monitor u0 (
    .CLK(CLK), .CLR(CLR), .ring_in(ring_in),
    .enable(enable), .clear_err(clear_err),
    .phase_idx(idx0), .phase_valid(valid0),
    .locked(locked0), .rev_count(rev0),
    .rev_tick(tick0), .err_onehot(eoh0),
    .err_seq(esq0), .err_count(ecnt0)
  );

  ring_phase_monitor #(.REV_W(2)) u1 (
    .CLK(CLK), .CLR(CLR), .ring_in(ring_in),
    .enable(enable), .clear_err(clear_err),
    .phase_idx(idx1), .phase_valid(valid1),
    .locked(locked1), .rev_count(rev1),
    .rev_tick(tick1), .err_onehot(eoh1),
    .err_seq(esq1), .err_count(ecnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_chk;
  int   n_pass;
  exp_t m;
  int   m_st;
  int   m_prev;
  int   cur;
  exp_t sbq[$];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m      = '{default: 0};
    m_st   = 0;
    m_prev = -1;
  endtask

  task automatic bump_err();
    if (m.ecnt < 15) m.ecnt++;
  endtask

  task automatic model_edge(input logic [3:0] r, input bit en,
                            input bit ce);
    bit oh;
    bit hit;
    int ri;
    bit wr;
    oh = ($countones(r) == 1);
    ri = 0;
    for (int i = 0; i < 4; i++) if (r[i]) ri = i;
    hit = oh && (m_prev >= 0) && (ri == (m_prev + 1) % 4);
    wr = hit && (m_prev == 3);
    m.tick = 0;
    if (ce) begin
      m.eoh = 0;
      m.esq = 0;
      m.ecnt = 0;
    end
    if (en) begin
      m.valid = oh;
      if (oh) m.idx = ri;
      case (m_st)
        0: if (oh) m_st = 1;
        1: begin
          if (hit) begin
            m_st = 2;
            if (wr) begin m.rev++; m.tick = 1; end
          end else if (!oh) m_st = 0;
        end
        default: begin
          if (hit) begin
            if (wr) begin m.rev++; m.tick = 1; end
          end else if (!oh) begin
            m.eoh = 1; bump_err(); m_st = 0;
          end else begin
            m.esq = 1; bump_err(); m_st = 1;
          end
        end
      endcase
      if (oh) m_prev = ri;
      m.locked = (m_st == 2);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    check("phase_idx", idx0, e.idx);
    check("phase_valid", valid0, e.valid);
    check("locked", locked0, e.locked);
    check("rev_count", rev0, e.rev % 256);
    check("rev_tick", tick0, e.tick);
    check("err_onehot", eoh0, e.eoh);
    check("err_seq", esq0, e.esq);
    check("err_count", ecnt0, e.ecnt);
    check("rev_count_w2", rev1, e.rev % 4);
    check("rev_tick_w2", tick1, e.tick);
    check("locked_w2", locked1, e.locked);
  endtask

  task automatic step(input logic [3:0] r, input bit en = 1,
                      input bit ce = 0);
    ring_in   = r;
    enable    = en;
    clear_err = ce;
    model_edge(r, en, ce);
    sbq.push_back(m);
    @(posedge CLK);
    #1;
    compare();
  endtask

  function automatic logic [3:0] ph(input int k);
    logic [3:0] v;
    v = 4'b0001 << (k % 4);
    return v;
  endfunction

  task automatic legal();
    cur = (cur + 1) % 4;
    step(ph(cur));
  endtask

  task automatic seq_err(input bit ce = 0);
    cur = (cur + 2) % 4;
    step(ph(cur), 1, ce);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    ring_in = 4'b0000;
    enable = 1'b0;
    clear_err = 1'b0;
    CLR = 1'b0;
    model_reset();
    #2;
    sbq.push_back(m);
    compare();
    @(negedge CLK);
    CLR = 1'b1;

    // legal lock and first revolution
    step(4'b0001);
    step(4'b0010);
    check("lock_after_2", locked0, 1);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    check("rev1_tick", tick0, 1);
    check("rev1_count", rev0, 1);

    // non-one-hot error at phase 2
    step(4'b0010);
    step(4'b0100);
    step(4'b0110);
    check("oh_err_idx", idx0, 2);
    check("oh_err_cnt", ecnt0, 1);
    step(4'b0001);
    step(4'b0010);
    check("relock", locked0, 1);

    // clear while disabled, then sequence error from 0010
    step(4'b1111, 0, 1);
    step(4'b1000);
    check("seq_err", esq0, 1);
    step(4'b0001);
    check("seq_relock_tick", tick0, 1);

    // enable low with garbage
    step(4'b0110, 0);
    step(4'b1111, 0);
    step(4'b0000, 0);
    step(4'b0010);
    check("hold_lock", locked0, 1);

    // five errors, then clear colliding with a sixth
    cur = 1;
    step(4'b0000, 0, 1);
    for (int i = 0; i < 5; i++) begin
      seq_err();
      legal();
    end
    check("five_errs", ecnt0, 5);
    seq_err(1);
    check("clr_vs_err_cnt", ecnt0, 1);
    check("clr_vs_err_flag", esq0, 1);
    legal();

    // saturation with mixed error kinds
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) begin
        step(4'b0101);
        legal();
        legal();
      end else begin
        seq_err();
        legal();
      end
    end
    check("saturate", ecnt0, 15);

    // five clean revolutions
    for (int i = 0; i < 20; i++) legal();
    legal();

    // async reset mid-revolution
    #2;
    CLR = 1'b0;
    #1;
    model_reset();
    sbq.push_back(m);
    compare();
    check("rst_idx_w2", idx1, 0);
    check("rst_ecnt_w2", ecnt1, 0);
    @(negedge CLK);
    CLR = 1'b1;
    cur = 3;
    for (int i = 0; i < 6; i++) legal();

    // randomised stretch
    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [3:0] r;
      bit en;
      bit ce;
      sel = $urandom_range(9);
      en = ($urandom_range(7) != 0);
      ce = ($urandom_range(15) == 0);
      if (sel < 7) begin
        cur = (cur + 1) % 4;
        r = ph(cur);
      end else if (sel == 7) begin
        r = 4'($urandom_range(15));
      end else begin
        cur = $urandom_range(3);
        r = ph(cur);
      end
      step(r, en, ce);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
